if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage: owns the program counter and drives the instruction-memory address.
- Captures the combinationally returned instruction word into the IF/ID pipeline register for the decode stage.
- Supports decode back-pressure (ready/valid), branch/jump redirect with flush, and a misaligned-PC trap that halts fetch until redirected.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_WORD, 32'h0000_0000, instruction word placed in IF/ID for bubbles and trapped entries

Ports:
clk  input  1  system clock; all state updates on posedge
rst  input  1  synchronous, active-high reset
im_addr  output  32  byte address to instruction memory; equals current PC (combinational from PC register)
im_data  input  32  instruction word returned combinationally by instruction memory for im_addr, same cycle
redirect_valid  input  1  branch/jump taken; load redirect_target this cycle
redirect_target  input  32  new PC (byte address)
id_ready  input  1  decode can accept the IF/ID entry this cycle
id_valid  output  1  IF/ID entry valid
id_pc  output  32  PC of the IF/ID instruction
id_instr  output  32  instruction word in IF/ID
id_pc_plus4  output  32  id_pc + 4 (mod 2^32)
id_misalign  output  1  IF/ID entry is a misaligned-fetch trap
fetch_count  output  32  number of instructions accepted into IF/ID since reset

Behaviour:
- Reset (rst=1 at posedge): pc=RESET_PC, state=RUN, id_valid=0, id_pc=0, id_instr=NOP_WORD, id_pc_plus4=0, id_misalign=0, fetch_count=0. rst overrides every other input. A redirect in the same cycle as rst is ignored.
- im_addr = pc at all times. The instruction memory indexes addr[9:2]; out-of-range addresses alias. This stage performs no range check.
- advance = !id_valid || id_ready.
- State machine: RUN, HALT.
- Priority per posedge: rst > redirect_valid > advance > hold.
- redirect_valid=1 (either state):
  - pc <= redirect_target; state <= RUN.
  - IF/ID is flushed: id_valid=0, id_instr=NOP_WORD, id_misalign=0. id_pc and id_pc_plus4 are don't-care but hold their values.
  - Applies regardless of id_ready. The word at the current pc is discarded and fetch_count is not incremented.
- RUN, advance=1, pc[1:0]==0:
  - IF/ID <= {valid=1, pc, im_data, pc+4, misalign=0}.
  - pc <= pc+4 (wraps 32'hFFFF_FFFC -> 0).
  - fetch_count++ (wraps at 2^32).
- RUN, advance=1, pc[1:0]!=0:
  - IF/ID <= {valid=1, pc, NOP_WORD, pc+4, misalign=1}.
  - pc holds; state <= HALT; fetch_count++.
- RUN, advance=0: pc, IF/ID and fetch_count all hold. The id_* outputs are stable while id_valid && !id_ready.
- HALT, no redirect:
  - pc holds; no new entries are loaded.
  - If advance=1, id_valid <= 0, so the trap entry is consumed once and then a bubble follows. If advance=0, IF/ID holds.
  - Only a redirect or rst leaves HALT.
- Latency: an instruction at pc appears on id_* one posedge after pc is presented, when advance=1. With id_ready held at 1, throughput is 1 instruction per cycle.
- The first valid IF/ID entry appears on the first posedge after rst deasserts.

Test Plan:
- Reset, then id_ready=1 for 4 cycles with mem[0..3]=11,22,33,44 -> id_instr sequence 11,22,33,44; id_pc 0,4,8,C; id_pc_plus4 4,8,C,10; fetch_count=4.
- Stall: id_ready=0 for 3 cycles while id_pc=8 -> id_* unchanged and pc=C held; release -> next entry id_pc=C, no instruction lost or duplicated.
- Redirect with target=0x40 while id_ready=0 and id_valid=1 -> next cycle id_valid=0 and im_addr=0x40; the following cycle id_pc=0x40, id_instr=mem[16]; fetch_count not incremented on the redirect cycle.
- Misaligned redirect to 0x42 -> entry id_pc=0x42, id_misalign=1, id_instr=NOP_WORD, then id_valid=0 and pc stuck at 0x42 for 5 cycles; redirect to 0x8 -> fetch resumes with id_pc=0x8, misalign=0.
- PC wrap: RESET_PC=32'hFFFF_FFFC -> first entry id_pc=FFFF_FFFC, id_pc_plus4=0; next entry id_pc=0.
- rst asserted mid-stream with redirect_valid=1 in the same cycle -> all outputs at reset values and im_addr=RESET_PC; the redirect has no effect.

Source files
------------

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage : instruction-fetch stage
//
// Owns the program counter, presents it to instruction memory, and captures the
// combinationally returned word into the IF/ID pipeline register. Supports
// decode back-pressure, branch/jump redirect with flush, and a misaligned-PC
// trap that stops fetching until a redirect arrives.
//
// Ports
//   clk              system clock, all state updates on posedge
//   rst              synchronous active-high reset
//   im_addr          byte address to instruction memory (= PC)
//   im_data          instruction word for im_addr, same cycle
//   redirect_valid   taken branch/jump: load redirect_target, flush IF/ID
//   redirect_target  new PC
//   id_ready         decode accepts the IF/ID entry this cycle
//   id_valid         IF/ID entry valid
//   id_pc            PC of the IF/ID entry
//   id_instr         instruction word of the IF/ID entry
//   id_pc_plus4      id_pc + 4
//   id_misalign      IF/ID entry is a misaligned-fetch trap
//   fetch_count      entries loaded into IF/ID since reset
// -----------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] im_addr,
  input  logic [31:0] im_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4,
  output logic        id_misalign,
  output logic [31:0] fetch_count
);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [31:0] r_pc;
  logic        r_id_valid;
  logic [31:0] r_id_pc;
  logic [31:0] r_id_instr;
  logic [31:0] r_id_pc_plus4;
  logic        r_id_misalign;
  logic [31:0] r_fetch_count;

  logic        w_advance;
  logic        w_aligned;
  logic [31:0] w_pc_plus4;
  logic        w_load;   // load a new entry (normal or trap) into IF/ID
  logic        w_drain;  // HALT: consumed entry is replaced by a bubble

  assign w_advance  = !r_id_valid || id_ready;
  assign w_aligned  = (r_pc[1:0] == 2'b00);
  assign w_pc_plus4 = r_pc + 32'd4;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: a redirect always restarts fetch; a misaligned fetch
  // that gets loaded parks the stage until the next redirect.
  always_comb begin
    w_state_next = r_state;
    if (redirect_valid) begin
      w_state_next = S_RUN;
    end else if (r_state == S_RUN && w_advance && !w_aligned) begin
      w_state_next = S_HALT;
    end
  end

  // Output/control decode
  always_comb begin
    w_load  = 1'b0;
    w_drain = 1'b0;
    if (!redirect_valid) begin
      case (r_state)
        S_RUN:   w_load  = w_advance;
        S_HALT:  w_drain = w_advance;
        default: ;
      endcase
    end
  end

  // PC and IF/ID datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_id_valid    <= 1'b0;
      r_id_pc       <= 32'd0;
      r_id_instr    <= NOP_WORD;
      r_id_pc_plus4 <= 32'd0;
      r_id_misalign <= 1'b0;
      r_fetch_count <= 32'd0;
    end else if (redirect_valid) begin
      // Flush: id_pc / id_pc_plus4 deliberately keep their old values.
      r_pc          <= redirect_target;
      r_id_valid    <= 1'b0;
      r_id_instr    <= NOP_WORD;
      r_id_misalign <= 1'b0;
    end else if (w_load) begin
      r_id_valid    <= 1'b1;
      r_id_pc       <= r_pc;
      r_id_pc_plus4 <= w_pc_plus4;
      r_id_instr    <= w_aligned ? im_data : NOP_WORD;
      r_id_misalign <= !w_aligned;
      r_fetch_count <= r_fetch_count + 32'd1;
      // A trapping PC is kept so the faulting address stays visible.
      if (w_aligned) begin
        r_pc <= w_pc_plus4;
      end
    end else if (w_drain) begin
      r_id_valid <= 1'b0;
    end
  end

  assign im_addr     = r_pc;
  assign id_valid    = r_id_valid;
  assign id_pc       = r_id_pc;
  assign id_instr    = r_id_instr;
  assign id_pc_plus4 = r_id_pc_plus4;
  assign id_misalign = r_id_misalign;
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage : self-checking bench for if_stage
//
// Directed sequence with hand-computed expectations. Entries expected to be
// handed to decode are queued; a monitor pops and compares every accepted
// IF/ID entry. A second instance with RESET_PC = FFFF_FFFC covers PC wrap.
// -----------------------------------------------------------------------------
module tb_if_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        misalign;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] im_addr, im_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_pc, id_instr, id_pc_plus4;
  logic        id_misalign;
  logic [31:0] fetch_count;

  // Wrap-test instance
  logic [31:0] w2_im_addr, w2_im_data;
  logic        w2_redirect_valid = 1'b0;
  logic [31:0] w2_redirect_target = 32'd0;
  logic        w2_id_ready = 1'b1;
  logic        w2_id_valid;
  logic [31:0] w2_id_pc, w2_id_instr, w2_id_pc_plus4;
  logic        w2_id_misalign;
  logic [31:0] w2_fetch_count;

  logic [31:0] mem [256];

  int checks = 0;
  int errors = 0;
  entry_t exp_q[$];

  always #5 clk = ~clk;

  assign im_data    = mem[im_addr[9:2]];
  assign w2_im_data = mem[w2_im_addr[9:2]];

  if_stage #(.RESET_PC(32'h0000_0000), .NOP_WORD(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .im_addr(im_addr), .im_data(im_data),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .id_ready(id_ready), .id_valid(id_valid),
    .id_pc(id_pc), .id_instr(id_instr), .id_pc_plus4(id_pc_plus4),
    .id_misalign(id_misalign), .fetch_count(fetch_count)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_WORD(32'h0000_0000)) dut_wrap (
    .clk(clk), .rst(rst),
    .im_addr(w2_im_addr), .im_data(w2_im_data),
    .redirect_valid(w2_redirect_valid), .redirect_target(w2_redirect_target),
    .id_ready(w2_id_ready), .id_valid(w2_id_valid),
    .id_pc(w2_id_pc), .id_instr(w2_id_instr), .id_pc_plus4(w2_id_pc_plus4),
    .id_misalign(w2_id_misalign), .fetch_count(w2_fetch_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] instr,
                      input logic [31:0] p4, input logic mis);
    entry_t e;
    e.pc = pc; e.instr = instr; e.pc_plus4 = p4; e.misalign = mis;
    exp_q.push_back(e);
  endtask

  // Monitor: every entry handed to decode must match the head of the queue.
  always @(negedge clk) begin
    if (!rst && id_valid && id_ready && !redirect_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected actual pc=%h instr=%h required=none", id_pc, id_instr);
      end else begin
        entry_t e;
        e = exp_q.pop_front();
        if (id_pc !== e.pc || id_instr !== e.instr ||
            id_pc_plus4 !== e.pc_plus4 || id_misalign !== e.misalign) begin
          errors++;
          $display("FAIL sb_entry actual pc=%h instr=%h p4=%h mis=%b required pc=%h instr=%h p4=%h mis=%b",
                   id_pc, id_instr, id_pc_plus4, id_misalign,
                   e.pc, e.instr, e.pc_plus4, e.misalign);
        end else begin
          $display("ok   sb_entry pc=%h instr=%h p4=%h mis=%b",
                   id_pc, id_instr, id_pc_plus4, id_misalign);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 + i;
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;

    rst = 1'b1; id_ready = 1'b0; redirect_valid = 1'b0; redirect_target = 32'd0;
    step(); step();
    chk("rst_valid",   {31'd0, id_valid}, 32'd0);
    chk("rst_pc",      id_pc, 32'd0);
    chk("rst_instr",   id_instr, 32'd0);
    chk("rst_pc4",     id_pc_plus4, 32'd0);
    chk("rst_mis",     {31'd0, id_misalign}, 32'd0);
    chk("rst_fc",      fetch_count, 32'd0);
    chk("rst_im_addr", im_addr, 32'd0);

    // Streaming fetch
    rst = 1'b0; id_ready = 1'b1;
    push(32'h0, 32'h11, 32'h4,  1'b0);
    push(32'h4, 32'h22, 32'h8,  1'b0);
    push(32'h8, 32'h33, 32'hC,  1'b0);
    push(32'hC, 32'h44, 32'h10, 1'b0);
    step();
    chk("wrap_pc1",    w2_id_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4_1",  w2_id_pc_plus4, 32'h0);
    chk("wrap_instr1", w2_id_instr, 32'hC0DE_00FF);
    step();
    chk("wrap_pc2",    w2_id_pc, 32'h0);
    chk("wrap_instr2", w2_id_instr, 32'h11);
    step();
    chk("pre_stall_pc", id_pc, 32'h8);

    // Stall with id_pc = 8
    id_ready = 1'b0;
    repeat (3) begin
      step();
      chk("stall_id_pc", id_pc, 32'h8);
      chk("stall_instr", id_instr, 32'h33);
      chk("stall_im",    im_addr, 32'hC);
      chk("stall_fc",    fetch_count, 32'd3);
    end
    id_ready = 1'b1;
    step();
    chk("rel_id_pc", id_pc, 32'hC);
    chk("rel_pc4",   id_pc_plus4, 32'h10);
    chk("rel_fc",    fetch_count, 32'd4);
    step();  // entry 0x10 loaded, will be flushed

    // Redirect while stalled
    id_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h40;
    step();
    chk("redir_valid", {31'd0, id_valid}, 32'd0);
    chk("redir_im",    im_addr, 32'h40);
    chk("redir_fc",    fetch_count, 32'd5);
    redirect_valid = 1'b0;
    step();
    chk("tgt_valid", {31'd0, id_valid}, 32'd1);
    chk("tgt_pc",    id_pc, 32'h40);
    chk("tgt_instr", id_instr, 32'hC0DE_0010);
    chk("tgt_fc",    fetch_count, 32'd6);

    // Misaligned redirect
    redirect_valid = 1'b1; redirect_target = 32'h42;
    step();
    chk("mis_redir_im",    im_addr, 32'h42);
    chk("mis_redir_valid", {31'd0, id_valid}, 32'd0);
    redirect_valid = 1'b0; id_ready = 1'b1;
    push(32'h42, 32'h0, 32'h46, 1'b1);
    step();
    chk("trap_mis",   {31'd0, id_misalign}, 32'd1);
    chk("trap_instr", id_instr, 32'h0);
    chk("trap_fc",    fetch_count, 32'd7);
    repeat (5) begin
      step();
      chk("halt_valid", {31'd0, id_valid}, 32'd0);
      chk("halt_im",    im_addr, 32'h42);
    end
    chk("halt_fc", fetch_count, 32'd7);

    // Recover from trap
    redirect_valid = 1'b1; redirect_target = 32'h8;
    step();
    redirect_valid = 1'b0;
    push(32'h8, 32'h33, 32'hC, 1'b0);
    step();
    step();
    id_ready = 1'b0;
    chk("resume_pc",  id_pc, 32'hC);
    chk("resume_mis", {31'd0, id_misalign}, 32'd0);

    // Reset with a simultaneous redirect
    rst = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h80;
    step();
    chk("rst2_valid", {31'd0, id_valid}, 32'd0);
    chk("rst2_pc",    id_pc, 32'd0);
    chk("rst2_instr", id_instr, 32'd0);
    chk("rst2_pc4",   id_pc_plus4, 32'd0);
    chk("rst2_mis",   {31'd0, id_misalign}, 32'd0);
    chk("rst2_fc",    fetch_count, 32'd0);
    chk("rst2_im",    im_addr, 32'd0);
    chk("rst2_wrap_im", w2_im_addr, 32'hFFFF_FFFC);
    rst = 1'b0; redirect_valid = 1'b0;

    chk("sb_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
